// File: rtl/acc_8bit_pkg.sv
// ----------------------------------------------------------------------------
// acc_8bit_pkg
// Shared definitions for the acc_8bit accumulator stage.
//   state_t  : FSM encoding (IDLE=0, ACC=1, DONE=2; 3 is illegal and
//              recovers to IDLE on the next clock).
//   SAT_VAL  : value the running total clamps to on carry-out when
//              saturation is enabled.
// ----------------------------------------------------------------------------
package acc_8bit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SAT_VAL = 8'hFF;

endpackage : acc_8bit_pkg

// File: rtl/add_8bit.sv
// ----------------------------------------------------------------------------
// add_8bit
// Unsigned 8-bit combinational adder with carry-out.
// Ports (positional order is part of the interface):
//   sum  : out [7:0]  a + b modulo 256
//   cout : out        carry out of bit 7
//   a    : in  [7:0]  first operand
//   b    : in  [7:0]  second operand
// ----------------------------------------------------------------------------
module add_8bit (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b
);

    logic [8:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[7:0];
    assign cout = full[8];

endmodule : add_8bit

// File: rtl/acc_8bit.sv
// ----------------------------------------------------------------------------
// acc_8bit
// Reduction stage behind the adder datapath. Accepts NUM_SAMPLES 8-bit
// samples over a valid/ready handshake, sums them through one add_8bit
// instance and presents the total plus a sticky overflow flag on an output
// valid/ready handshake.
//
// Parameters:
//   NUM_SAMPLES : samples per result, 1..255
//   SATURATE    : 1 = clamp total to 8'hFF on carry-out, 0 = wrap mod 256
//   CNT_W       : sample counter width, 2**CNT_W > NUM_SAMPLES
//
// Ports:
//   clk       : in   rising-edge clock
//   rst       : in   asynchronous active-high reset
//   clear     : in   synchronous abort, drops the partial sum
//   in_valid  : in   din valid
//   in_ready  : out  block can accept din (not in DONE)
//   din       : in   [7:0] sample
//   out_valid : out  dout/ovf hold a completed result
//   out_ready : in   downstream consumes the result
//   dout      : out  [7:0] accumulated total
//   ovf       : out  sticky carry-out flag for this accumulation
// ----------------------------------------------------------------------------
module acc_8bit #(
    parameter int unsigned NUM_SAMPLES = 4,
    parameter bit          SATURATE    = 1'b1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] din,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] dout,
    output logic       ovf
);

    import acc_8bit_pkg::*;

    localparam logic [CNT_W-1:0] NS_CNT  = CNT_W'(NUM_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             accept;
    logic             rel;
    logic             last;
    logic [7:0]       add_a;
    logic [7:0]       sum;
    logic             cout;
    logic [7:0]       total_next;

    // Clamp or wrap the adder result depending on SATURATE.
    function automatic logic [7:0] sat_total(input logic [7:0] s, input logic c);
        if (c && SATURATE) begin
            return SAT_VAL;
        end
        return s;
    endfunction

    assign in_ready  = (state != DONE);
    assign out_valid = (state == DONE);
    assign dout      = acc;

    assign accept    = in_valid && in_ready;
    assign rel       = out_valid && out_ready;

    // count is 0 in IDLE, so the same "is this the last sample" test covers
    // both the first sample (NUM_SAMPLES==1) and later ones.
    assign count_inc = count + CNT_ONE;
    assign last      = (count_inc == NS_CNT);

    // In IDLE the acc register is already zero, but forcing the operand
    // makes the first-sample load independent of acc contents.
    assign add_a = (state == IDLE) ? 8'h00 : acc;

    add_8bit u_add (sum, cout, add_a, din);

    assign total_next = sat_total(sum, cout);

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, ACC: begin
                    if (accept) begin
                        state_next = last ? DONE : ACC;
                    end
                end
                DONE: begin
                    if (rel) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= 8'h00;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            acc   <= 8'h00;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, ACC: begin
                    // ovf is already 0 in IDLE, so OR-ing in cout is safe there.
                    if (accept) begin
                        acc   <= total_next;
                        ovf   <= ovf | cout;
                        count <= count_inc;
                    end
                end
                DONE: begin
                    if (rel) begin
                        acc   <= 8'h00;
                        count <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: begin
                    acc   <= 8'h00;
                    count <= '0;
                    ovf   <= 1'b0;
                end
            endcase
        end
    end

endmodule : acc_8bit

// File: tb/tb_acc_8bit.sv
// ----------------------------------------------------------------------------
// tb_acc_8bit
// Bench for acc_8bit. Two instances share all inputs: u_sat (SATURATE=1)
// and u_wrap (SATURATE=0), both with NUM_SAMPLES=4. Their handshakes never
// depend on SATURATE, so they stay in lockstep and are checked together.
// ----------------------------------------------------------------------------
module tb_acc_8bit;

    typedef struct packed {
        logic [7:0] d1;
        logic       o1;
        logic [7:0] d0;
        logic       o0;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic [7:0] din;
    logic       out_ready;

    logic       in_ready1, out_valid1, ovf1;
    logic [7:0] dout1;
    logic       in_ready0, out_valid0, ovf0;
    logic [7:0] dout0;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;

    acc_8bit #(.NUM_SAMPLES(4), .SATURATE(1'b1), .CNT_W(8)) u_sat (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready1), .din(din),
        .out_valid(out_valid1), .out_ready(out_ready),
        .dout(dout1), .ovf(ovf1)
    );

    acc_8bit #(.NUM_SAMPLES(4), .SATURATE(1'b0), .CNT_W(8)) u_wrap (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready0), .din(din),
        .out_valid(out_valid0), .out_ready(out_ready),
        .dout(dout0), .ovf(ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step: returns {acc, ovf} after adding one sample.
    function automatic logic [8:0] step(input logic [7:0] a, input logic o,
                                        input logic [7:0] x, input bit sat);
        logic [8:0] t;
        t = {1'b0, a} + {1'b0, x};
        if (t[8] && sat) return {8'hFF, 1'b1};
        return {t[7:0], o | t[8]};
    endfunction

    // Sends the first n samples of s (written order, s[3] first), with gap
    // idle cycles between samples. Ends on the negedge after the last accept.
    // A full batch with push set queues the expected result.
    task automatic send_batch(input logic [3:0][7:0] s, input int n,
                              input bit push, input int gap);
        logic [7:0] a1, a0;
        logic       o1, o0;
        logic [8:0] r;
        a1 = 8'h00; a0 = 8'h00; o1 = 1'b0; o0 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            din      = s[3-i];
            r  = step(a1, o1, s[3-i], 1'b1); a1 = r[8:1]; o1 = r[0];
            r  = step(a0, o0, s[3-i], 1'b0); a0 = r[8:1]; o0 = r[0];
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    din      = 8'hEE;
                    n_cmp++;
                    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || dout1 !== a1) begin
                        n_err++;
                        $display("FAIL gap_hold: got ov=%b ir=%b dout=%h, want ov=0 ir=1 dout=%h",
                                 out_valid1, in_ready1, dout1, a1);
                    end
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (push && n == 4) sb.push_back('{d1: a1, o1: o1, d0: a0, o0: o0});
    endtask

    // Waits (bounded) for a result, checks it against the scoreboard head,
    // then releases it and checks the return to IDLE.
    task automatic collect(input string name);
        int   w;
        exp_t e;
        w = 0;
        while (out_valid1 !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (out_valid1 !== 1'b1) begin
            n_err++;
            $display("FAIL %s_timeout: out_valid=%b, want 1 within 40 cycles", name, out_valid1);
            return;
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL %s_sb_empty: result seen, want queued expectation", name);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (dout1 !== e.d1 || ovf1 !== e.o1) begin
            n_err++;
            $display("FAIL %s_sat: got dout=%h ovf=%b, want dout=%h ovf=%b", name, dout1, ovf1, e.d1, e.o1);
        end
        n_cmp++;
        if (out_valid0 !== 1'b1 || dout0 !== e.d0 || ovf0 !== e.o0) begin
            n_err++;
            $display("FAIL %s_wrap: got ov=%b dout=%h ovf=%b, want ov=1 dout=%h ovf=%b",
                     name, out_valid0, dout0, ovf0, e.d0, e.o0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || dout1 !== 8'h00 || ovf1 !== 1'b0) begin
            n_err++;
            $display("FAIL %s_release: got ov=%b ir=%b dout=%h ovf=%b, want 0 1 00 0",
                     name, out_valid1, in_ready1, dout1, ovf1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; din = 8'h00; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid1 !== 1'b0 || dout1 !== 8'h00 || ovf1 !== 1'b0 || in_ready1 !== 1'b1) begin
            n_err++;
            $display("FAIL reset: got ov=%b dout=%h ovf=%b ir=%b, want 0 00 0 1",
                     out_valid1, dout1, ovf1, in_ready1);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_batch({8'h0A, 8'h14, 8'h1E, 8'h28}, 4, 1'b1, 0);
        // Must already be valid one negedge after the 4th accept.
        n_cmp++;
        if (out_valid1 !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: out_valid=%b, want 1", out_valid1);
        end
        n_cmp++;
        if (dout1 !== 8'h64 || ovf1 !== 1'b0) begin
            n_err++;
            $display("FAIL basic_value: got dout=%h ovf=%b, want 64 0", dout1, ovf1);
        end
        collect("basic");
    endtask

    task automatic test_overflow();
        send_batch({8'h80, 8'h90, 8'h01, 8'h01}, 4, 1'b1, 0);
        n_cmp++;
        if (dout1 !== 8'hFF || ovf1 !== 1'b1 || dout0 !== 8'h12 || ovf0 !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_values: got sat=%h/%b wrap=%h/%b, want FF/1 12/1", dout1, ovf1, dout0, ovf0);
        end
        collect("ovf");
    endtask

    task automatic test_backpressure();
        send_batch({8'h03, 8'h04, 8'h05, 8'h06}, 4, 1'b1, 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; din = 8'h55; out_ready = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (in_ready1 !== 1'b0 || out_valid1 !== 1'b1 || dout1 !== 8'h12 || ovf1 !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold: got ir=%b ov=%b dout=%h ovf=%b, want 0 1 12 0",
                         in_ready1, out_valid1, dout1, ovf1);
            end
        end
        in_valid = 1'b0;
        collect("bp");
        send_batch({8'h01, 8'h01, 8'h01, 8'h01}, 4, 1'b1, 0);
        collect("bp_next");
    endtask

    task automatic test_gaps();
        send_batch({8'h01, 8'h02, 8'h03, 8'h04}, 4, 1'b1, 3);
        collect("gaps");
    endtask

    task automatic test_clear();
        send_batch({8'hF0, 8'hF0, 8'h00, 8'h00}, 2, 1'b0, 0);
        n_cmp++;
        if (dout1 !== 8'hFF || ovf1 !== 1'b1 || dout0 !== 8'hE0 || ovf0 !== 1'b1) begin
            n_err++;
            $display("FAIL clear_partial: got sat=%h/%b wrap=%h/%b, want FF/1 E0/1", dout1, ovf1, dout0, ovf0);
        end
        clear = 1'b1; in_valid = 1'b1; din = 8'h07;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid1 !== 1'b0 || dout1 !== 8'h00 || ovf1 !== 1'b0 || dout0 !== 8'h00) begin
            n_err++;
            $display("FAIL clear_state: got ov=%b dout=%h ovf=%b wrap=%h, want 0 00 0 00",
                     out_valid1, dout1, ovf1, dout0);
        end
        send_batch({8'h01, 8'h01, 8'h01, 8'h01}, 4, 1'b1, 0);
        collect("clear_next");
    endtask

    task automatic test_async_reset();
        send_batch({8'hF0, 8'hF0, 8'h00, 8'h00}, 2, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid1 !== 1'b0 || dout1 !== 8'h00 || ovf1 !== 1'b0) begin
            n_err++;
            $display("FAIL arst_acc: got ov=%b dout=%h ovf=%b, want 0 00 0", out_valid1, dout1, ovf1);
        end
        #1 rst = 1'b0;
        send_batch({8'h50, 8'h50, 8'h50, 8'h50}, 4, 1'b0, 0);
        n_cmp++;
        if (out_valid1 !== 1'b1 || dout1 !== 8'hFF || ovf1 !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre_done: got ov=%b dout=%h ovf=%b, want 1 FF 1", out_valid1, dout1, ovf1);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid1 !== 1'b0 || dout1 !== 8'h00 || ovf1 !== 1'b0 || out_valid0 !== 1'b0) begin
            n_err++;
            $display("FAIL arst_done: got ov=%b dout=%h ovf=%b, want 0 00 0", out_valid1, dout1, ovf1);
        end
        #1 rst = 1'b0;
        send_batch({8'h10, 8'h10, 8'h10, 8'h10}, 4, 1'b1, 0);
        collect("arst_next");
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_gaps();
        test_clear();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d results outstanding, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_acc_8bit

// File: doc/acc_8bit.md
Name: acc_8bit

Overview:
Sequential accumulator stage that sits directly downstream of add_8bit and consumes its sum/cout outputs. It accepts a stream of 8-bit samples over a valid/ready handshake and feeds the running total plus each new sample into an add_8bit instance. After NUM_SAMPLES accepted samples it presents the 8-bit total and an overflow flag on an output valid/ready handshake. Used as the reduction stage behind the adder datapath.

Parameters:
NUM_SAMPLES, 4, samples summed per result; legal range 1..255.
SATURATE, 1, 1 = clamp total to 8'hFF on carry-out; 0 = wrap modulo 256.
CNT_W, 8, width of sample counter; must satisfy 2**CNT_W > NUM_SAMPLES.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous abort; discards the partial sum and returns to IDLE.
in_valid  input  1  din is valid this cycle.
in_ready  output  1  block can accept din this cycle.
din  input  8  sample to accumulate.
out_valid  output  1  dout/ovf hold a completed result.
out_ready  input  1  downstream consumes the result this cycle.
dout  output  8  accumulated total.
ovf  output  1  sticky flag: a carry-out occurred during this accumulation.

Behaviour:
- Reset is asynchronous and active-high. Clock and reset ports are clk and rst.
- On rst: state=IDLE, acc=8'h00, count=0, ovf=0, out_valid=0. dout reflects acc, so dout=8'h00.
- An accept occurs when in_valid && in_ready on a clk edge. A release occurs when out_valid && out_ready.
- Adder hookup: add_8bit a=acc, b=din. In IDLE, a is forced to 8'h00 so the first sample loads directly.
- Next total: if cout && SATURATE then 8'hFF, else sum.
- ovf_next = ovf | cout. With SATURATE=1 and acc=8'hFF, any nonzero sample sets ovf again; the flag is sticky in either case.
- in_ready = (state != DONE), combinational from state. din is never sampled in DONE.
- out_valid = (state == DONE), decoded from the registered state.
- IDLE: acc=0, ovf=0, count=0.
  - On accept: acc <= din, count <= 1.
  - Go to ACC, or directly to DONE if NUM_SAMPLES==1.
- ACC: on accept: acc <= next total, ovf <= ovf_next, count <= count+1.
  - If count+1 == NUM_SAMPLES, go to DONE; otherwise stay in ACC.
  - No accept: hold all state. Gaps in in_valid are allowed indefinitely.
- DONE: dout and ovf are stable while out_valid=1.
  - On release: go to IDLE with acc=0, ovf=0, count=0.
  - The first sample of the next batch is accepted no earlier than the cycle after the release.
- Latency: out_valid rises on the clk edge that accepts the NUM_SAMPLES-th sample, i.e. one cycle after it is presented. Minimum throughput is NUM_SAMPLES+1 cycles per result.
- clear (synchronous) beats any accept or release in the same cycle: state=IDLE, acc=0, count=0, ovf=0, and the sample presented that cycle is dropped.
- Asynchronous rst mid-batch or mid-DONE discards everything immediately. out_valid drops without waiting for clk.
- count never wraps: it is bounded by NUM_SAMPLES.

Decomposition:
- Package acc_8bit_pkg holds:
  - State encoding IDLE=2'd0, ACC=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Constant SAT_VAL=8'hFF.
- The single sub-module is add_8bit, instanced once, with positional ports (sum, cout, a, b).
- The FSM, counter and saturation mux live in acc_8bit.

Test Plan:
1. NUM_SAMPLES=4, SATURATE=1, accept 8'h0A, 8'h14, 8'h1E, 8'h28 back-to-back -> out_valid=1 on the edge after the 4th accept; dout=8'h64, ovf=0.
2. SATURATE=1, samples 8'h80, 8'h90, 8'h01, 8'h01 -> dout=8'hFF, ovf=1. With SATURATE=0, the same samples -> dout=8'h12, ovf=1.
3. Back-pressure: hold out_ready=0 for 5 cycles while driving in_valid=1 with din=8'h55 -> in_ready=0, dout/ovf/out_valid stable. Then set out_ready=1 -> IDLE next cycle, and the next result excludes 8'h55 samples offered during DONE.
4. In-valid gaps: samples 1, 2, 3, 4 each separated by 3 idle cycles -> dout=8'h0A; state holds during the gaps.
5. clear asserted after 2 samples (8'hF0, 8'hF0, so ovf=1), together with in_valid and din=8'h07 -> 8'h07 dropped. Next batch 1, 1, 1, 1 -> dout=8'h04, ovf=0.
6. rst pulsed between clk edges in ACC and again in DONE -> out_valid, dout, ovf go to 0 immediately, and a following batch of 4×8'h10 gives dout=8'h40.
